sipo_frame_ctrl: RTL and testbench

//   Framing controller for the serial-in/parallel-out shift path. Sequences bit

---
 rtl/sipo_frame_ctrl_if.sv | 15 +
 rtl/sipo_frame_ctrl.sv | 73 +++++++
 tb/tb_sipo_frame_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_ctrl_if.sv
// sipo_frame_ctrl_if: serial capture inputs and parallel valid/ready output of the framing controller.
interface sipo_frame_ctrl_if #(parameter int WIDTH = 4);
    logic                         start, shift_in, shift_en, frame_abort, out_ready, clear_ovr;
    logic [WIDTH-1:0]             parallel_out;
    logic                         out_valid, busy, overrun;
    logic [$clog2(WIDTH+1)-1:0]   bit_cnt;
    modport master (
        output start, shift_in, shift_en, frame_abort, out_ready, clear_ovr,
        input  parallel_out, out_valid, busy, overrun, bit_cnt
    );
    modport slave (
        input  start, shift_in, shift_en, frame_abort, out_ready, clear_ovr,
        output parallel_out, out_valid, busy, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: frames WIDTH serial bits into a word and offers it on a valid/ready port,
// flagging a sticky overrun when a finished word finds the output still occupied.
module sipo_frame_ctrl #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    sipo_frame_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH+1);
    typedef enum logic {IDLE, SHIFT} state_e;
    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d, pout_q, pout_d, word;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d, ovr_q, ovr_d;
    // Shift register contents including the bit arriving this cycle
    assign word = MSB_FIRST ? {sreg_q[WIDTH-2:0], bus.shift_in} : {bus.shift_in, sreg_q[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            pout_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            pout_q  <= pout_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        pout_d  = pout_q;
        cnt_d   = cnt_q;
        valid_d = valid_q & ~bus.out_ready;
        ovr_d   = ovr_q & ~bus.clear_ovr;
        if (state_q == IDLE) begin
            if (bus.start) begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
        end else if (bus.frame_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.shift_en) begin
            sreg_d = word;
            if (cnt_q == CW'(WIDTH-1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                // A word still waiting to be taken keeps the port; the new one is lost
                if (!valid_q || bus.out_ready) begin
                    pout_d  = word;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end
    assign bus.parallel_out = pout_q;
    assign bus.out_valid    = valid_q;
    assign bus.busy         = (state_q == SHIFT);
    assign bus.bit_cnt      = cnt_q;
    assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// tb_sipo_frame_ctrl: three framer configurations share one stimulus stream; a bit-position
// reference model feeds per-instance expected-word queues drained by a negedge monitor.
module tb_sipo_frame_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, sin = 1'b0, sen = 1'b0, abort = 1'b0, rdy = 1'b0, clr = 1'b0;
    int   checks = 0, fails = 0;

    sipo_frame_ctrl_if #(.WIDTH(4)) if0 ();
    sipo_frame_ctrl_if #(.WIDTH(4)) if1 ();
    sipo_frame_ctrl_if #(.WIDTH(8)) if2 ();
    assign {if0.start, if0.shift_in, if0.shift_en, if0.frame_abort, if0.out_ready, if0.clear_ovr} = {start, sin, sen, abort, rdy, clr};
    assign {if1.start, if1.shift_in, if1.shift_en, if1.frame_abort, if1.out_ready, if1.clear_ovr} = {start, sin, sen, abort, rdy, clr};
    assign {if2.start, if2.shift_in, if2.shift_en, if2.frame_abort, if2.out_ready, if2.clear_ovr} = {start, sin, sen, abort, rdy, clr};

    sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sipo_frame_ctrl #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    sipo_frame_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic [7:0] d_pout [3];
    logic [3:0] d_cnt  [3];
    logic       d_valid[3], d_busy[3], d_ovr[3];
    assign d_pout[0] = 8'(if0.parallel_out);
    assign d_pout[1] = 8'(if1.parallel_out);
    assign d_pout[2] = if2.parallel_out;
    assign d_cnt[0]  = 4'(if0.bit_cnt);
    assign d_cnt[1]  = 4'(if1.bit_cnt);
    assign d_cnt[2]  = if2.bit_cnt;
    assign {d_valid[0], d_busy[0], d_ovr[0]} = {if0.out_valid, if0.busy, if0.overrun};
    assign {d_valid[1], d_busy[1], d_ovr[1]} = {if1.out_valid, if1.busy, if1.overrun};
    assign {d_valid[2], d_busy[2], d_ovr[2]} = {if2.out_valid, if2.busy, if2.overrun};

    always #5 clk = ~clk;

    // Reference model: bit k of a frame lands at a fixed word position; no shift register
    int         W [3] = '{4, 4, 8};
    bit         MF[3] = '{1'b1, 1'b0, 1'b1};
    int         m_cnt[3];
    bit         m_shift[3], m_valid[3], m_ovr[3];
    logic [7:0] m_acc[3];
    logic [7:0] exp_q[3][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_shift[k] = 0; m_valid[k] = 0; m_ovr[k] = 0; m_acc[k] = '0;
            exp_q[k].delete();
        end
    endtask

    task automatic model_step();
        bit nv, st;
        for (int k = 0; k < 3; k++) begin
            nv = m_valid[k] && !rdy;
            st = 1'b0;
            if (!m_shift[k]) begin
                if (start) begin m_shift[k] = 1; m_cnt[k] = 0; m_acc[k] = '0; end
            end else if (abort) begin
                m_shift[k] = 0; m_cnt[k] = 0;
            end else if (sen) begin
                m_acc[k][MF[k] ? W[k]-1-m_cnt[k] : m_cnt[k]] = sin;
                if (m_cnt[k] == W[k]-1) begin
                    m_shift[k] = 0; m_cnt[k] = 0;
                    if (!m_valid[k] || rdy) begin nv = 1; exp_q[k].push_back(m_acc[k]); end
                    else st = 1;
                end else m_cnt[k]++;
            end
            m_ovr[k]   = st || (m_ovr[k] && !clr);
            m_valid[k] = nv;
        end
    endtask

    // Inputs change 2 time units after each rising edge; the model sees the pre-edge values
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic frame(input logic [7:0] b, input int n, input int gap, input bit rdy_last);
        start = 1; tick(); start = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap, 0)) begin sen = 0; sin = 1'($urandom); tick(); end
            sen = 1; sin = b[n-1-i]; rdy = rdy_last && (i == n-1); tick();
        end
        sen = 0; rdy = 0;
    endtask

    task automatic consume();
        rdy = 1; tick(); rdy = 0;
    endtask

    task automatic all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_pout%0d", tag, k), d_pout[k], 0);
            chk($sformatf("%s_flags%0d", tag, k), {d_valid[k], d_busy[k], d_ovr[k]}, 0);
            chk($sformatf("%s_cnt%0d", tag, k), d_cnt[k], 0);
        end
    endtask

    // Monitor: cycle state compared every negedge; a word is popped when it is handed over
    initial forever begin
        @(negedge clk);
        if (rst_n) for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy%0d", k), d_busy[k], m_shift[k]);
            chk($sformatf("cnt%0d", k), d_cnt[k], m_cnt[k]);
            chk($sformatf("valid%0d", k), d_valid[k], m_valid[k]);
            chk($sformatf("ovr%0d", k), d_ovr[k], m_ovr[k]);
            if (m_valid[k] && rdy && exp_q[k].size() > 0)
                chk($sformatf("word%0d", k), d_pout[k], exp_q[k].pop_front());
        end
    end

    initial begin
        model_reset();
        tick(); tick();
        all_zero("reset");
        rst_n = 1;
        // Back-to-back bits
        frame(8'b1011, 4, 0, 0);
        chk("t1_pout", d_pout[0], 32'hB);
        chk("t1_valid", d_valid[0], 1);
        chk("t1_busy", d_busy[0], 0);
        chk("t1_lsb_pout", d_pout[1], 32'hD);
        consume();
        chk("t1_consumed", d_valid[0], 0);
        // Gaps between bits
        frame(8'b1011, 4, 3, 0);
        chk("t2_pout", d_pout[0], 32'hB);
        consume();
        // Overrun, clear, then a same-edge handover
        frame(8'b1011, 4, 1, 0);
        frame(8'b0110, 4, 1, 0);
        chk("t3_kept", d_pout[0], 32'hB);
        chk("t3_ovr", d_ovr[0], 1);
        clr = 1; tick(); clr = 0;
        chk("t3_clr", d_ovr[0], 0);
        frame(8'b0110, 4, 0, 1);
        chk("t3_swap", d_pout[0], 32'h6);
        chk("t3_noovr", d_ovr[0], 0);
        consume();
        // Abort, then start held high while shifting
        start = 1; tick(); start = 0;
        sen = 1; sin = 1; tick(); tick(); sen = 0;
        abort = 1; tick(); abort = 0;
        chk("t4_busy", d_busy[0], 0);
        chk("t4_cnt", d_cnt[0], 0);
        chk("t4_valid", d_valid[0], 0);
        start = 1; tick();
        sen = 1;
        sin = 0; tick(); sin = 1; tick(); sin = 1; tick();
        start = 0; sin = 0; tick(); sen = 0;
        chk("t4_pout", d_pout[0], 32'h6);
        consume();
        // Asynchronous reset mid-frame
        abort = 1; tick(); abort = 0;
        start = 1; tick(); start = 0;
        sen = 1; sin = 1; tick(); tick(); tick(); sen = 0;
        #1 rst_n = 0; model_reset();
        #1 all_zero("arst");
        tick(); rst_n = 1;
        frame(8'b1101, 4, 2, 0);
        chk("t5_pout", d_pout[0], 32'hD);
        chk("t5_lsb_pout", d_pout[1], 32'hB);
        consume();
        // Eight-bit frame
        abort = 1; tick(); abort = 0;
        consume();
        frame(8'b10110010, 8, 1, 0);
        chk("t6_w8", d_pout[2], 32'hB2);
        chk("t6_w8_valid", d_valid[2], 1);
        chk("t6_lsb_pout", d_pout[1], 32'hD);
        consume();
        // Random traffic
        repeat (400) begin
            start = $urandom_range(99) < 20;
            sen   = $urandom_range(99) < 60;
            sin   = 1'($urandom);
            abort = $urandom_range(99) < 3;
            rdy   = $urandom_range(99) < 40;
            clr   = $urandom_range(99) < 5;
            tick();
        end
        {start, sen, sin, clr} = '0;
        abort = 1; rdy = 1;
        repeat (3) tick();
        abort = 0; rdy = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain_q%0d", k), exp_q[k].size(), 0);
            chk($sformatf("drain_valid%0d", k), d_valid[k], 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
